// File: rtl/ws2812_serializer.sv
// WS2812 frame serializer: on each frame_start rising edge, fetches NUM_LEDS GRB words
// from a one-cycle-latency read port and shifts them out gaplessly, followed by a latch period.
module ws2812_serializer #(
    parameter int NUM_LEDS       = 60,
    parameter int SEGMENT_CYCLES = 4,
    parameter int RESET_CYCLES   = 3600
) (
    input  logic        clock_12mhz,
    input  logic        reset_n,
    input  logic        frame_start,
    output logic        pixel_read,
    output logic [9:0]  pixel_address,
    input  logic [23:0] pixel_data,
    output logic        data_out,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_overrun
);

    localparam int BIT_CYCLES = 4 * SEGMENT_CYCLES;
    localparam int CW = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
    localparam int LW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;

    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] SEG_ONE  = CW'(SEGMENT_CYCLES);
    localparam logic [CW-1:0] SEG_TWO  = CW'(2 * SEGMENT_CYCLES);
    localparam logic [9:0]    LAST_PIX = 10'(NUM_LEDS - 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(RESET_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

    state_t        state_q, state_d;
    logic          fs_q, fs_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [4:0]    bit_q, bit_d;
    logic [9:0]    pix_q, pix_d;
    logic [23:0]   shift_q, shift_d;
    logic [23:0]   pf_q, pf_d;
    logic          pf_pend_q, pf_pend_d;
    logic [LW-1:0] lat_q, lat_d;
    logic          data_out_q, data_out_d;
    logic          frame_done_q, frame_done_d;
    logic          overrun_q, overrun_d;

    logic edge_det;
    logic start;
    logic prefetch;

    always_comb begin
        edge_det = frame_start & ~fs_q;
        // The read for pixel 0 is issued in the edge cycle itself, so gate it while in reset.
        start    = reset_n & edge_det & (state_q == IDLE);
        prefetch = (state_q == SHIFT) && (bit_q == 5'd23) && (cyc_q == '0) && (pix_q != LAST_PIX);

        state_d      = state_q;
        fs_d         = frame_start;
        cyc_d        = cyc_q;
        bit_d        = bit_q;
        pix_d        = pix_q;
        shift_d      = shift_q;
        pf_pend_d    = prefetch;
        pf_d         = pf_pend_q ? pixel_data : pf_q;
        lat_d        = lat_q;
        frame_done_d = 1'b0;
        overrun_d    = edge_det && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                shift_d = pixel_data;
                bit_d   = 5'd0;
                cyc_d   = '0;
                pix_d   = 10'd0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d = '0;
                    if (bit_q == 5'd23) begin
                        if (pix_q == LAST_PIX) begin
                            state_d = LATCH;
                            lat_d   = '0;
                        end else begin
                            pix_d   = pix_q + 10'd1;
                            bit_d   = 5'd0;
                            shift_d = pf_q;
                        end
                    end else begin
                        bit_d   = bit_q + 5'd1;
                        shift_d = {shift_q[22:0], 1'b0};
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            LATCH: begin
                if (lat_q == LAT_LAST) begin
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Counters hold the position of the bit cell being driven, so the line level is
        // derived from the next position to keep data_out registered with no extra lag.
        data_out_d = (state_d == SHIFT) &&
                     ((cyc_d < SEG_ONE) || (shift_d[23] && (cyc_d < SEG_TWO)));
    end

    always_ff @(posedge clock_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            fs_q         <= 1'b0;
            cyc_q        <= '0;
            bit_q        <= 5'd0;
            pix_q        <= 10'd0;
            shift_q      <= 24'd0;
            pf_q         <= 24'd0;
            pf_pend_q    <= 1'b0;
            lat_q        <= '0;
            data_out_q   <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            fs_q         <= fs_d;
            cyc_q        <= cyc_d;
            bit_q        <= bit_d;
            pix_q        <= pix_d;
            shift_q      <= shift_d;
            pf_q         <= pf_d;
            pf_pend_q    <= pf_pend_d;
            lat_q        <= lat_d;
            data_out_q   <= data_out_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign pixel_read    = start | prefetch;
    assign pixel_address = prefetch ? (pix_q + 10'd1) : 10'd0;
    assign data_out      = data_out_q;
    // Busy stays up through the frame_done cycle even though the FSM is already idle.
    assign busy          = start | (state_q != IDLE) | frame_done_q;
    assign frame_done    = frame_done_q;
    assign frame_overrun = overrun_q;

endmodule

// File: tb/tb_ws2812_serializer.sv
// Scoreboard bench for ws2812_serializer (NUM_LEDS=2): stimulus pushes expected reads, pixels,
// latch lengths, busy lengths and overrun timings; a monitor decodes the line and compares.
module tb_ws2812_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic        pixel_read;
    logic [9:0]  pixel_address;
    logic [23:0] pixel_data = 24'd0;
    logic        data_out;
    logic        busy;
    logic        frame_done;
    logic        frame_overrun;

    logic [23:0] mem [0:1];

    int n_total = 0;
    int n_pass  = 0;

    int          exp_rd[$];
    logic [23:0] exp_pix[$];
    int          exp_done[$];
    int          exp_busy[$];
    int          exp_ovr[$];

    ws2812_serializer #(.NUM_LEDS(2), .SEGMENT_CYCLES(4), .RESET_CYCLES(3600)) dut (
        .clock_12mhz  (clk),
        .reset_n      (rst_n),
        .frame_start  (frame_start),
        .pixel_read   (pixel_read),
        .pixel_address(pixel_address),
        .pixel_data   (pixel_data),
        .data_out     (data_out),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_overrun(frame_overrun)
    );

    always #5 clk = ~clk;

    // Frame buffer: one-cycle read latency.
    always @(posedge clk) begin
        if (pixel_read) pixel_data <= mem[pixel_address[0]];
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- monitor ----------------
    int          hi_cnt = 0, lo_cnt = 0, gap_cnt = 0, frame_bits = 0, since_rd0 = 0, busy_cnt = 0;
    logic        in_bit = 1'b0, prev_do = 1'b0, prev_rd = 1'b0, b;
    logic [23:0] word = 24'd0;

    always @(negedge clk) begin
        if (!rst_n) begin
            hi_cnt = 0; lo_cnt = 0; gap_cnt = 0; frame_bits = 0; busy_cnt = 0;
            in_bit = 1'b0; prev_do = 1'b0; prev_rd = 1'b0;
        end else begin
            since_rd0++;
            if (frame_done) begin
                chk("latch_low_cycles", gap_cnt, exp_done.size() > 0 ? exp_done.pop_front() : -1);
                $display("frame_done after %0d low cycles", gap_cnt);
                frame_bits = 0;
            end
            if (data_out) begin
                if (!prev_do) begin
                    if (in_bit) chk("bit_period", hi_cnt + lo_cnt, 16);
                    if (frame_bits == 0) chk("first_rise_latency", since_rd0, 2);
                    else chk("gapless", gap_cnt, 0);
                    in_bit = 1'b1; hi_cnt = 0; lo_cnt = 0; gap_cnt = 0;
                end
                hi_cnt++;
            end else if (in_bit) begin
                lo_cnt++;
                if (hi_cnt + lo_cnt == 16) begin
                    b = (hi_cnt == 8);
                    if (!b) chk("bit0_high_time", hi_cnt, 4);
                    word = {word[22:0], b};
                    frame_bits++;
                    in_bit = 1'b0;
                    gap_cnt = 0;
                    if (frame_bits % 24 == 0) begin
                        chk("pixel_word", word, exp_pix.size() > 0 ? exp_pix.pop_front() : -1);
                        $display("pixel word 0x%06h", word);
                    end
                end
            end else begin
                gap_cnt++;
            end
            prev_do = data_out;

            if (pixel_read) begin
                chk("read_not_consecutive", prev_rd, 0);
                chk("read_addr", pixel_address, exp_rd.size() > 0 ? exp_rd.pop_front() : -1);
                $display("read addr %0d", pixel_address);
                if (pixel_address == 10'd0) begin
                    since_rd0 = 0;
                end else begin
                    chk("prefetch_bit_index", frame_bits, pixel_address * 24 - 1);
                    chk("prefetch_first_cycle", hi_cnt, 1);
                end
            end
            prev_rd = pixel_read;

            if (frame_overrun) begin
                chk("overrun_timing", since_rd0, exp_ovr.size() > 0 ? exp_ovr.pop_front() : -1);
                $display("overrun at cycle %0d of frame", since_rd0);
            end

            if (busy) busy_cnt++;
            else if (busy_cnt > 0) begin
                chk("busy_length", busy_cnt, exp_busy.size() > 0 ? exp_busy.pop_front() : -1);
                $display("busy for %0d cycles", busy_cnt);
                busy_cnt = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic expect_frame(input logic [23:0] w0, input logic [23:0] w1);
        exp_rd.push_back(0);
        exp_rd.push_back(1);
        exp_pix.push_back(w0);
        exp_pix.push_back(w1);
        exp_done.push_back(3600);
        exp_busy.push_back(2 * 384 + 3600 + 3);
    endtask

    task automatic start_pulse();
        @(posedge clk); #1 frame_start = 1'b1;
        repeat (4) @(posedge clk);
        #1 frame_start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        frame_start = 1'b0;
        mem[0] = 24'hFF0000;
        mem[1] = 24'h000001;
        repeat (3) @(posedge clk);
        #1 frame_start = 1'b1;
        #1;
        chk("rst_data_out", data_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pixel_read", pixel_read, 0);
        chk("rst_pixel_address", pixel_address, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_overrun", frame_overrun, 0);
        frame_start = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Single frame with gapless pixel boundary.
        expect_frame(24'hFF0000, 24'h000001);
        start_pulse();
        repeat (5000) @(posedge clk);

        // Second edge 1000 cycles into the frame.
        mem[0] = 24'h5A3C0F;
        mem[1] = 24'h00FF81;
        expect_frame(24'h5A3C0F, 24'h00FF81);
        exp_ovr.push_back(1001);
        start_pulse();
        repeat (996) @(posedge clk);
        #1 frame_start = 1'b1;
        repeat (4) @(posedge clk);
        #1 frame_start = 1'b0;
        repeat (4000) @(posedge clk);

        // Asynchronous reset during pixel 0 bit 5 (all-ones word keeps the line high there).
        mem[0] = 24'hFFFFFF;
        mem[1] = 24'hFFFFFF;
        exp_rd.push_back(0);
        start_pulse();
        repeat (84) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midreset_data_out", data_out, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_frame_done", frame_done, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        mem[0] = 24'hC30096;
        mem[1] = 24'h7E0102;
        expect_frame(24'hC30096, 24'h7E0102);
        start_pulse();
        repeat (5000) @(posedge clk);

        // Level-held frame_start gives exactly one frame and no overrun.
        mem[0] = 24'h123456;
        mem[1] = 24'hFEDCBA;
        expect_frame(24'h123456, 24'hFEDCBA);
        @(posedge clk); #1 frame_start = 1'b1;
        repeat (50000) @(posedge clk);
        #1 frame_start = 1'b0;
        repeat (20) @(posedge clk);

        chk("pending_reads", exp_rd.size(), 0);
        chk("pending_pixels", exp_pix.size(), 0);
        chk("pending_done", exp_done.size(), 0);
        chk("pending_busy", exp_busy.size(), 0);
        chk("pending_overrun", exp_ovr.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
